// File: rtl/pipe_stage_skid.sv
// Pipeline stage with a one-entry skid buffer: full throughput with a registered in_ready.
// Bubbles zero the control payload and are counted in a saturating counter.
module pipe_stage_skid #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CTRL_WIDTH = 8,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [CTRL_WIDTH-1:0] in_ctrl,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CTRL_WIDTH-1:0] out_ctrl,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [CNT_WIDTH-1:0]  bubble_cnt
);

  logic                  out_valid_q, out_valid_d;
  logic [CTRL_WIDTH-1:0] out_ctrl_q, out_ctrl_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  skid_valid_q, skid_valid_d;
  logic [CTRL_WIDTH-1:0] skid_ctrl_q, skid_ctrl_d;
  logic [DATA_WIDTH-1:0] skid_data_q, skid_data_d;
  logic [CNT_WIDTH-1:0]  bubble_cnt_q, bubble_cnt_d;

  logic accept;
  logic out_free;

  // in_ready comes straight from a flop, so out_ready never reaches it combinationally.
  assign in_ready = ~skid_valid_q;
  assign accept   = in_valid & in_ready;
  assign out_free = ~out_valid_q | out_ready;

  always_comb begin
    out_valid_d  = out_valid_q;
    out_ctrl_d   = out_ctrl_q;
    out_data_d   = out_data_q;
    skid_valid_d = skid_valid_q;
    skid_ctrl_d  = skid_ctrl_q;
    skid_data_d  = skid_data_q;

    if (flush) begin
      out_valid_d  = 1'b0;
      out_ctrl_d   = '0;
      skid_valid_d = 1'b0;
      skid_ctrl_d  = '0;
    end else if (out_free) begin
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_ctrl_d   = skid_ctrl_q;
        out_data_d   = skid_data_q;
        skid_valid_d = accept;
        if (accept) begin
          skid_ctrl_d = in_ctrl;
          skid_data_d = in_data;
        end
      end else begin
        out_valid_d  = accept;
        skid_valid_d = 1'b0;
        if (accept) begin
          out_ctrl_d = in_ctrl;
          out_data_d = in_data;
        end else begin
          out_ctrl_d = '0;
        end
      end
    end else if (accept) begin
      skid_valid_d = 1'b1;
      skid_ctrl_d  = in_ctrl;
      skid_data_d  = in_data;
    end
  end

  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    if (!out_valid_q && (bubble_cnt_q != {CNT_WIDTH{1'b1}})) begin
      bubble_cnt_d = bubble_cnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      out_ctrl_q   <= '0;
      out_data_q   <= '0;
      skid_valid_q <= 1'b0;
      skid_ctrl_q  <= '0;
      skid_data_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_ctrl_q   <= out_ctrl_d;
      out_data_q   <= out_data_d;
      skid_valid_q <= skid_valid_d;
      skid_ctrl_q  <= skid_ctrl_d;
      skid_data_q  <= skid_data_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_ctrl   = out_valid_q ? out_ctrl_q : '0;
  assign out_data   = out_data_q;
  assign bubble_cnt = bubble_cnt_q;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid: reset, bubble counter saturation, streaming,
// backpressure through the skid entry, flush and asynchronous reset.
module tb_pipe_stage_skid;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_ctrl;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_ctrl;
  logic [31:0] out_data;
  logic [3:0]  bubble_cnt;

  int total;
  int bad;

  pipe_stage_skid #(
    .DATA_WIDTH(32),
    .CTRL_WIDTH(8),
    .CNT_WIDTH (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ctrl   (in_ctrl),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ctrl  (out_ctrl),
    .out_data  (out_data),
    .bubble_cnt(bubble_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] c, input logic [31:0] d);
    in_valid = v;
    in_ctrl  = c;
    in_data  = d;
  endtask

  task automatic test_reset();
    #2;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    total++; if (out_ctrl !== 8'h00) begin bad++; $display("FAIL reset_out_ctrl got=%h want=00", out_ctrl); end
    total++; if (out_data !== 32'h0) begin bad++; $display("FAIL reset_out_data got=%h want=0", out_data); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    total++; if (bubble_cnt !== 4'd0) begin bad++; $display("FAIL reset_bubble_cnt got=%0d want=0", bubble_cnt); end
    step();
    total++; if (bubble_cnt !== 4'd0) begin bad++; $display("FAIL reset_held_cnt got=%0d want=0", bubble_cnt); end
    rst = 1'b0;
  endtask

  task automatic test_bubble_sat();
    for (int i = 0; i < 14; i++) step();
    total++; if (bubble_cnt !== 4'd14) begin bad++; $display("FAIL bubble_cnt_14 got=%0d want=14", bubble_cnt); end
    step();
    total++; if (bubble_cnt !== 4'd15) begin bad++; $display("FAIL bubble_cnt_15 got=%0d want=15", bubble_cnt); end
    for (int i = 0; i < 5; i++) step();
    total++; if (bubble_cnt !== 4'd15) begin bad++; $display("FAIL bubble_cnt_sat got=%0d want=15", bubble_cnt); end
  endtask

  task automatic test_single();
    out_ready = 1'b1;
    drive(1'b1, 8'h05, 32'h10);
    step();
    drive(1'b0, 8'h00, 32'h0);
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL single_valid got=%b want=1", out_valid); end
    total++; if (out_ctrl !== 8'h05) begin bad++; $display("FAIL single_ctrl got=%h want=05", out_ctrl); end
    total++; if (out_data !== 32'h10) begin bad++; $display("FAIL single_data got=%h want=10", out_data); end
    step();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL single_drain_valid got=%b want=0", out_valid); end
    total++; if (out_ctrl !== 8'h00) begin bad++; $display("FAIL bubble_ctrl got=%h want=00", out_ctrl); end
  endtask

  task automatic test_stream();
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 8'(8'h40 + i), 32'(i));
      step();
      total++;
      if (out_valid !== 1'b1 || out_data !== 32'(i) || out_ctrl !== 8'(8'h40 + i)) begin
        bad++;
        $display("FAIL stream_%0d got v=%b d=%h c=%h want v=1 d=%h c=%h",
                 i, out_valid, out_data, out_ctrl, 32'(i), 8'(8'h40 + i));
      end
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL stream_ready_%0d got=%b want=1", i, in_ready); end
    end
    drive(1'b0, 8'h00, 32'h0);
    step();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL stream_end_valid got=%b want=0", out_valid); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    drive(1'b1, 8'h11, 32'hA);
    step();
    total++; if (out_data !== 32'hA || out_valid !== 1'b1) begin bad++; $display("FAIL bp_a_loaded got v=%b d=%h want v=1 d=a", out_valid, out_data); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_ready_a got=%b want=1", in_ready); end
    drive(1'b1, 8'h22, 32'hB);
    step();
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_ready_skid got=%b want=0", in_ready); end
    total++; if (out_data !== 32'hA || out_ctrl !== 8'h11) begin bad++; $display("FAIL bp_a_held got d=%h c=%h want d=a c=11", out_data, out_ctrl); end
    // D is offered while full and must never be accepted.
    drive(1'b1, 8'h44, 32'hD);
    step();
    total++; if (out_data !== 32'hA || in_ready !== 1'b0) begin bad++; $display("FAIL bp_stall got d=%h r=%b want d=a r=0", out_data, in_ready); end
    drive(1'b0, 8'h00, 32'h0);
    out_ready = 1'b1;
    step();
    total++; if (out_valid !== 1'b1 || out_data !== 32'hB || out_ctrl !== 8'h22) begin bad++; $display("FAIL bp_b_out got v=%b d=%h c=%h want v=1 d=b c=22", out_valid, out_data, out_ctrl); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_ready_back got=%b want=1", in_ready); end
    step();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_no_d got v=%b d=%h want v=0", out_valid, out_data); end
  endtask

  task automatic test_flush();
    // Both entries full, C offered while flushing.
    out_ready = 1'b0;
    drive(1'b1, 8'h11, 32'hA);
    step();
    drive(1'b1, 8'h22, 32'hB);
    step();
    drive(1'b1, 8'h33, 32'hC);
    flush = 1'b1;
    step();
    flush = 1'b0;
    drive(1'b0, 8'h00, 32'h0);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_full_valid got=%b want=0", out_valid); end
    total++; if (out_ctrl !== 8'h00) begin bad++; $display("FAIL flush_full_ctrl got=%h want=00", out_ctrl); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL flush_full_ready got=%b want=1", in_ready); end
    out_ready = 1'b1;
    step();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_full_leak got v=%b d=%h want v=0", out_valid, out_data); end
    // Only OUT full, so C would be accepted without the flush.
    out_ready = 1'b0;
    drive(1'b1, 8'h11, 32'hA);
    step();
    drive(1'b1, 8'h33, 32'hC);
    flush = 1'b1;
    step();
    flush = 1'b0;
    drive(1'b0, 8'h00, 32'h0);
    out_ready = 1'b1;
    total++; if (out_valid !== 1'b0 || out_ctrl !== 8'h00) begin bad++; $display("FAIL flush_half got v=%b c=%h want v=0 c=00", out_valid, out_ctrl); end
    step();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_half_leak got v=%b d=%h want v=0", out_valid, out_data); end
    total++; if (bubble_cnt !== 4'd15) begin bad++; $display("FAIL flush_keeps_cnt got=%0d want=15", bubble_cnt); end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    drive(1'b1, 8'h11, 32'hA);
    step();
    drive(1'b1, 8'h22, 32'hB);
    step();
    drive(1'b0, 8'h00, 32'h0);
    total++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin bad++; $display("FAIL async_pre got r=%b v=%b want r=0 v=1", in_ready, out_valid); end
    #2;
    rst = 1'b1;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL async_valid got=%b want=0", out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL async_ready got=%b want=1", in_ready); end
    total++; if (out_data !== 32'h0 || out_ctrl !== 8'h00) begin bad++; $display("FAIL async_payload got d=%h c=%h want 0", out_data, out_ctrl); end
    total++; if (bubble_cnt !== 4'd0) begin bad++; $display("FAIL async_cnt got=%0d want=0", bubble_cnt); end
    step();
    rst = 1'b0;
    out_ready = 1'b1;
    step();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL async_after got v=%b d=%h want v=0", out_valid, out_data); end
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    rst       = 1'b1;
    flush     = 1'b0;
    out_ready = 1'b0;
    drive(1'b0, 8'h00, 32'h0);
    test_reset();
    test_bubble_sat();
    test_single();
    test_stream();
    test_backpressure();
    test_flush();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_stage_skid.md
PIPE_STAGE_SKID -- requirements
Module: pipe_stage_skid

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: width of the datapath payload (PC, operand values, immediates, destination).
REQ-002 SHALL have parameter CTRL_WIDTH, default 8: width of the control payload (wb_en, mem_r_en, mem_w_en, b, s, ...), zeroed on bubble.
REQ-003 SHALL have parameter CNT_WIDTH, default 16: width of the bubble counter.
REQ-004 clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, asynchronous and active-high.
REQ-006 flush  input  1  synchronous squash of all held entries.
REQ-007 in_valid  input  1  upstream presents an entry.
REQ-008 in_ready  output  1  stage can accept an entry this cycle.
REQ-009 in_ctrl  input  CTRL_WIDTH  control payload.
REQ-010 in_data  input  DATA_WIDTH  datapath payload.
REQ-011 out_valid  output  1  output entry is valid.
REQ-012 out_ready  input  1  downstream accepts the output entry this cycle.
REQ-013 out_ctrl  output  CTRL_WIDTH  control payload; all zeros whenever out_valid=0.
REQ-014 out_data  output  DATA_WIDTH  datapath payload; value is don't-care when out_valid=0.
REQ-015 bubble_cnt  output  CNT_WIDTH  saturating count of cycles with out_valid=0.

Function
REQ-016 SHALL hold two entries: an output register (OUT) and a skid register (SKID), each with a valid bit, ctrl and data.
REQ-017 SHALL drive in_ready = NOT SKID.valid, as a registered signal with no combinational path from out_ready.
REQ-018 SHALL accept an input when in_valid=1 and in_ready=1; SHALL leave the accepted entry unaltered.
REQ-019 SHALL complete an output transfer when out_valid=1 and out_ready=1.
REQ-020 When OUT is empty or transferring: SHALL load OUT from SKID if SKID.valid=1, else from the accepted input; SKID SHALL then empty (or hold a new accepted input when SKID was the source).
REQ-021 When OUT is full and not transferring: an accepted input SHALL go to SKID.
REQ-022 SHALL give a latency of 1 cycle from acceptance to out_valid when the stage is empty.
REQ-023 SHALL sustain full throughput of 1 entry/cycle when out_ready=1 continuously.
REQ-024 SHALL preserve order; no entry is dropped or duplicated except on flush.
REQ-025 When out_valid=0, SHALL drive out_ctrl to 0 (bubble), so downstream write/memory enables are inert.
REQ-026 On flush=1, SHALL clear OUT.valid, SKID.valid, OUT.ctrl and SKID.ctrl at the next edge; the input presented in that cycle SHALL be discarded; in_ready=1 and out_valid=0 in the following cycle.
REQ-027 flush SHALL take priority over simultaneous accept and transfer; an output transfer in the flush cycle still counts as delivered downstream.
REQ-028 SHALL increment bubble_cnt each cycle where out_valid=0, and SHALL saturate at 2^CNT_WIDTH-1 without wrap; flush SHALL NOT clear it.

Reset
REQ-029 While rst=1: OUT.valid=0, SKID.valid=0, all ctrl and data registers=0, bubble_cnt=0; hence out_valid=0, out_ctrl=0, out_data=0, in_ready=1.
REQ-030 Reset asserted mid-operation SHALL discard all held entries immediately, without waiting for a clock edge.

Verification
REQ-031 Reset, then in_valid=1, ctrl=0x05, data=0x00000010, out_ready=1 -> out_valid=1, out_ctrl=0x05, out_data=0x10 one cycle later.
REQ-032 Stream data 1,2,3,4 with out_ready=1 -> outputs 1,2,3,4 on consecutive cycles and in_ready stays 1.
REQ-033 OUT holds A with out_ready=0; push B -> B enters SKID and in_ready=0 next cycle; raise out_ready -> A then B in order, and in_ready returns to 1.
REQ-034 OUT=A, SKID=B, flush=1 with in_valid=1 (C) -> next cycle out_valid=0, out_ctrl=0, in_ready=1; C never appears on the output.
REQ-035 CNT_WIDTH=4, idle for 20 cycles after reset -> bubble_cnt=15 and holds at 15.
REQ-036 Assert rst asynchronously between edges while both entries are full -> out_valid=0 and in_ready=1 immediately, before the next clock edge.
